// File: rtl/sram_fifo_ctrl_if.sv
// Stream + SRAM-side bundle for sram_fifo_ctrl.
// Optional almost_full appears with SRAM_FIFO_AFULL_EN.
interface sram_fifo_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              wr_valid;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_ready;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic              full;
  logic              empty;
  logic              sram_rst;
  logic              sram_we;
  logic              sram_en;
  logic [ADDR_W-1:0] sram_w_addr;
  logic [ADDR_W-1:0] sram_r_addr;
  logic [WIDTH-1:0]  sram_data_w;
  logic [WIDTH-1:0]  sram_data_r;
`ifdef SRAM_FIFO_AFULL_EN
  logic              almost_full;
`endif

  modport slave (
    input  flush, wr_valid, wr_data, rd_req, sram_data_r,
    output wr_ready, rd_ready, rd_valid, rd_data,
    output full, empty,
`ifdef SRAM_FIFO_AFULL_EN
    output almost_full,
`endif
    output sram_rst, sram_we, sram_en,
    output sram_w_addr, sram_r_addr, sram_data_w
  );

  modport master (
    output flush, wr_valid, wr_data, rd_req, sram_data_r,
    input  wr_ready, rd_ready, rd_valid, rd_data,
    input  full, empty,
`ifdef SRAM_FIFO_AFULL_EN
    input  almost_full,
`endif
    input  sram_rst, sram_we, sram_en,
    input  sram_w_addr, sram_r_addr, sram_data_w
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for a 16x8 sync dual-port SRAM, one op per cycle.
// Optional registered almost_full output: define SRAM_FIFO_AFULL_EN.
module sram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4
`ifdef SRAM_FIFO_AFULL_EN
  ,
  parameter int AF_LEVEL = 12
`endif
) (
  input logic             clk,
  input logic             rst,
  sram_fifo_ctrl_if.slave bus
);
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic P_WRITE = 1'b0;
  localparam logic P_READ  = 1'b1;
  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_prio;
  logic              r_rd_valid;

  logic              w_run;
  logic              w_full;
  logic              w_empty;
  logic              w_can_w;
  logic              w_can_r;
  logic              w_gnt_w;
  logic              w_gnt_r;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_run   = (r_state == S_RUN) && !bus.flush;
  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);
  assign w_can_w = bus.wr_valid && !w_full;
  assign w_can_r = bus.rd_req && !w_empty;

  // Contention is settled by r_prio; a lone requester always wins.
  assign w_gnt_w = w_run && w_can_w &&
    (!w_can_r || r_prio == P_WRITE);
  assign w_gnt_r = w_run && w_can_r &&
    (!w_can_w || r_prio == P_READ);

  always_comb begin
    w_count_nxt = r_count;
    if (!w_run)
      w_count_nxt = '0;
    else if (w_gnt_w)
      w_count_nxt = r_count + 1'b1;
    else if (w_gnt_r)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_CLEAR;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_prio     <= P_WRITE;
      r_rd_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_state    <= S_RUN;
          r_rd_valid <= 1'b0;
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state    <= S_CLEAR;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
          end else begin
            if (w_gnt_w)
              r_wptr <= r_wptr + 1'b1;
            if (w_gnt_r)
              r_rptr <= r_rptr + 1'b1;
            if (w_can_w && w_can_r)
              r_prio <= ~r_prio;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_gnt_r;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

`ifdef SRAM_FIFO_AFULL_EN
  localparam logic [ADDR_W:0] AF_THR =
    AF_LEVEL[ADDR_W:0];

  logic r_afull;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_afull <= 1'b0;
    else if (!w_run)
      r_afull <= 1'b0;
    else
      r_afull <= (w_count_nxt >= AF_THR);
  end

  assign bus.almost_full = r_afull;
`endif

  assign bus.wr_ready = w_run && !w_full &&
    !(w_can_r && (!w_can_w || r_prio == P_READ));
  assign bus.rd_ready = w_run && !w_empty &&
    !(w_can_w && (!w_can_r || r_prio == P_WRITE));

  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = bus.sram_data_r;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.sram_rst    = (r_state == S_CLEAR);
  assign bus.sram_we     = w_gnt_w;
  assign bus.sram_en     = w_gnt_r;
  assign bus.sram_w_addr = r_wptr;
  assign bus.sram_r_addr = r_rptr;
  assign bus.sram_data_w = bus.wr_data;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural 16x8 SRAM.
// Scoreboard queue fed by accepted pushes, drained on rd_valid.
module tb_sram_fifo_ctrl;
  logic clk;
  logic rst;

  sram_fifo_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus ();

  sram_fifo_ctrl #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] sram_q;

  always @(posedge clk) begin
    if (bus.sram_rst) begin
      sram_q <= 8'h00;
    end else begin
      if (bus.sram_we)
        mem[bus.sram_w_addr] <= bus.sram_data_w;
      if (bus.sram_en)
        sram_q <= mem[bus.sram_r_addr];
    end
  end
  assign bus.sram_data_r = sram_q;

  int         checks = 0;
  int         errors = 0;
  int         n_pops = 0;
  logic [7:0] sb [$];
  logic [3:0] m_wptr = '0;
  logic [3:0] m_rptr = '0;
  logic [7:0] last_rd = '0;

  always @(posedge clk) begin
    if (bus.sram_we || bus.sram_en) begin
      checks++;
      if (bus.sram_we && bus.sram_en) begin
        errors++;
        $display("FAIL we_en_excl got we=1 en=1 exp not both");
      end
    end
    if (rst && bus.flush) begin
      sb.delete();
      m_wptr = '0;
      m_rptr = '0;
    end else if (rst) begin
      if (bus.wr_valid && bus.wr_ready) begin
        sb.push_back(bus.wr_data);
        m_wptr = m_wptr + 4'd1;
      end
      if (bus.rd_req && bus.rd_ready)
        m_rptr = m_rptr + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      checks++;
      n_pops++;
      last_rd = bus.rd_data;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got=%0h exp=none",
                 bus.rd_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (bus.rd_data !== exp) begin
          errors++;
          $display("FAIL rd_data got=%0h exp=%0h",
                   bus.rd_data, exp);
        end
      end
    end
  end

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.sram_rst !== 1'b1 || bus.wr_ready !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 ||
        bus.full !== 1'b0 || bus.sram_we !== 1'b0 ||
        bus.sram_en !== 1'b0 || bus.sram_w_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_vals got rst=%b wrdy=%b e=%b f=%b",
               bus.sram_rst, bus.wr_ready, bus.empty, bus.full);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sram_rst !== 1'b1) begin
      errors++;
      $display("FAIL clear_cycle got=%b exp=1", bus.sram_rst);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.sram_rst !== 1'b0 || bus.wr_ready !== 1'b1 ||
        bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_init got rst=%b wrdy=%b e=%b f=%b v=%b",
               bus.sram_rst, bus.wr_ready, bus.empty,
               bus.full, bus.rd_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h10 + 8'(i);
      #1;
      checks++;
      if (bus.sram_we !== 1'b1 || bus.sram_w_addr !== 4'(i)) begin
        errors++;
        $display("FAIL fill_addr got we=%b a=%0d exp we=1 a=%0d",
                 bus.sram_we, bus.sram_w_addr, i);
      end
    end
    @(negedge clk);
    bus.wr_data = 8'h20;
    #1;
    checks++;
    if (bus.full !== 1'b1 || bus.wr_ready !== 1'b0 ||
        bus.sram_we !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got f=%b wrdy=%b we=%b exp 1 0 0",
               bus.full, bus.wr_ready, bus.sram_we);
    end
`ifdef SRAM_FIFO_AFULL_EN
    checks++;
    if (bus.almost_full !== 1'b1) begin
      errors++;
      $display("FAIL afull got=%b exp=1", bus.almost_full);
    end
`endif
    @(negedge clk);
    idle();
  endtask

  task automatic test_drain();
    int g;
    int p0;
    g  = 0;
    p0 = n_pops;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b1;
      #1;
      if (bus.rd_ready === 1'b1) g++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (g != 16 || bus.empty !== 1'b1 || bus.rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain got g=%0d e=%b rrdy=%b exp 16 1 0",
               g, bus.empty, bus.rd_ready);
    end
    idle();
    @(negedge clk);
    checks++;
    if (n_pops - p0 != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_count got=%0d left=%0d exp 16 0",
               n_pops - p0, sb.size());
    end
  endtask

  task automatic test_contention();
    string got;
    string exp;
    logic [7:0] d;
    int n;
    got = "";
    exp = "WRWRWR";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    idle();
    d = 8'hB0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.rd_req   = 1'b1;
      bus.wr_data  = d;
      #1;
      if (bus.sram_we) begin
        got = {got, "W"};
        d++;
      end else if (bus.sram_en) begin
        got = {got, "R"};
      end else begin
        got = {got, "-"};
      end
    end
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL contention got=%s exp=%s", got, exp);
    end
    @(negedge clk);
    idle();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b1;
      #1;
      if (bus.rd_ready === 1'b1) n++;
      if (bus.empty === 1'b1) break;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL cont_count got=%0d exp=4", n);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int p0;
    p0 = n_pops;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.rd_req   = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h40 + 8'(i);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      bus.rd_req   = 1'b1;
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (n_pops - p0 != 40 || sb.size() != 0 ||
        bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count got=%0d left=%0d e=%b exp 40 0 1",
               n_pops - p0, sb.size(), bus.empty);
    end
    checks++;
    if (bus.sram_w_addr !== m_wptr ||
        bus.sram_r_addr !== m_rptr) begin
      errors++;
      $display("FAIL wrap_ptr got w=%0d r=%0d exp w=%0d r=%0d",
               bus.sram_w_addr, bus.sram_r_addr, m_wptr, m_rptr);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h60 + 8'(i);
    end
    @(negedge clk);
    bus.flush   = 1'b1;
    bus.rd_req  = 1'b1;
    bus.wr_data = 8'h6F;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0 ||
        bus.sram_we !== 1'b0 || bus.sram_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_gate got wrdy=%b rrdy=%b exp 0 0",
               bus.wr_ready, bus.rd_ready);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.sram_rst !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear got=%b exp=1", bus.sram_rst);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.sram_rst !== 1'b0 ||
        bus.sram_w_addr !== 4'd0 || bus.sram_r_addr !== 4'd0) begin
      errors++;
      $display("FAIL flush_state got e=%b w=%0d r=%0d exp 1 0 0",
               bus.empty, bus.sram_w_addr, bus.sram_r_addr);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (last_rd !== 8'h77 || sb.size() != 0) begin
      errors++;
      $display("FAIL flush_pop got=%0h exp=77", last_rd);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h80 + 8'(i);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b1;
    @(negedge clk);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h90;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.sram_rst !== 1'b1 ||
        bus.wr_ready !== 1'b0 || bus.sram_we !== 1'b0 ||
        bus.empty !== 1'b1 || bus.sram_w_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_rst got v=%b rst=%b wrdy=%b e=%b",
               bus.rd_valid, bus.sram_rst, bus.wr_ready, bus.empty);
    end
    sb.delete();
    m_wptr = '0;
    m_rptr = '0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL post_rst got wrdy=%b e=%b exp 1 1",
               bus.wr_ready, bus.empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_contention();
    test_wrap();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the 16x8 synchronous dual-port SRAM; the SRAM holds the storage.
- Converts a push/pop stream interface into the SRAM's we/en/w_addr/r_addr/data_w controls, and returns SRAM read data with a valid strobe.
- Enforces the SRAM's one-operation-per-cycle rule: we and en are never both high.
- Drives the SRAM's synchronous active-high clear.

Parameters:
- WIDTH, 8, data width; equals SRAM width.
- ADDR_W, 4, SRAM address width; depth = 2**ADDR_W = 16.
- AF_LEVEL, 12, almost-full threshold (optional feature only).

Ports:
- clk  input  1  rising-edge clock, shared with the SRAM.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous request to empty the FIFO.
- wr_valid  input  1  push request.
- wr_data  input  WIDTH  push data.
- wr_ready  output  1  push accepted this cycle when wr_valid && wr_ready.
- rd_req  input  1  pop request.
- rd_ready  output  1  pop accepted this cycle when rd_req && rd_ready.
- rd_valid  output  1  rd_data valid; one-cycle pulse.
- rd_data  output  WIDTH  popped word; wired from sram_data_r.
- full  output  1  count == 16.
- empty  output  1  count == 0.
- sram_rst  output  1  to SRAM rst; active-high, synchronous at the SRAM.
- sram_we  output  1  to SRAM we.
- sram_en  output  1  to SRAM en.
- sram_w_addr  output  ADDR_W  to SRAM w_addr.
- sram_r_addr  output  ADDR_W  to SRAM r_addr.
- sram_data_w  output  WIDTH  to SRAM data_w.
- sram_data_r  input  WIDTH  from SRAM data_r.

Behaviour:
- State machine CLEAR / RUN.
  - rst low (async) forces CLEAR, wptr = rptr = 0, count = 0, rd_valid = 0, prio = WRITE.
  - CLEAR: sram_rst = 1, sram_we = sram_en = 0, wr_ready = rd_ready = 0. Next state is always RUN; CLEAR lasts exactly one cycle after rst rises.
  - RUN with flush = 1: next state CLEAR; pointers, count and rd_valid clear at that edge. Any push or pop in that cycle is ignored; wr_ready and rd_ready are 0 while flush = 1.
- Reset values:
  - wr_ready = rd_ready = rd_valid = 0, sram_rst = 1, sram_we = sram_en = 0.
  - empty = 1, full = 0, addresses = 0.
- Grant logic (RUN, flush = 0):
  - can_w = wr_valid && !full; can_r = rd_req && !empty.
  - If both are set, prio picks the winner; prio toggles after every contended cycle (round-robin).
  - Otherwise the single requester wins.
  - wr_ready = !full && !(can_r && (!can_w || prio == READ)).
  - rd_ready = !empty && !(can_w && (!can_r || prio == WRITE)).
- Write grant: sram_we = 1, sram_w_addr = wptr, sram_data_w = wr_data; wptr++ (wraps 15->0), count++.
- Read grant: sram_en = 1, sram_r_addr = rptr; rptr++ (wraps), count--.
  - rd_valid = 1 the following cycle; rd_data = sram_data_r (SRAM registered output) in that cycle.
- Read-after-write: a word pushed in cycle N is poppable from N+1, because count updates at the N edge. Data is correct because the SRAM write commits at the same edge.
- Never sram_we && sram_en. Idle cycles drive both 0; the SRAM holds state.
- Pop latency is 1 cycle. Throughput is 1 op/cycle total. Sustained push+pop alternates, giving each side 1/2 rate.
- Full: wr_ready = 0, pops still served. Empty: rd_ready = 0, pushes still served.
- count is ADDR_W+1 bits, range 0..16.

Optional Feature:
- Macro SRAM_FIFO_AFULL_EN.
- Defined: adds output almost_full (1 bit), registered, = (count_next >= AF_LEVEL); reset value 0, cleared in CLEAR.
- Undefined: almost_full port and logic absent; AF_LEVEL unused.

Test Plan:
- Reset/init: rst low for 3 cycles, then high -> sram_rst = 1 for exactly one cycle, then wr_ready = 1, empty = 1, full = 0, rd_valid = 0.
- Fill: push 0x10..0x1F on 16 consecutive cycles -> full = 1 after the 16th, wr_ready = 0, sram_w_addr 0..15; a 17th push is not accepted.
- Drain: pop 16 consecutive cycles -> rd_valid the cycle after each grant with rd_data 0x10..0x1F in order; empty = 1, rd_ready = 0.
- Contention: 4 entries stored, wr_valid and rd_req held high 6 cycles -> grants alternate W,R,W,R,W,R; sram_we and sram_en never both 1; count returns to 4.
- Wrap: push/pop 40 words of an incrementing pattern, interleaved -> pointers wrap 15->0 twice; output sequence matches input with no loss or duplication.
- Flush and async reset mid-stream:
  - 5 entries stored, assert flush -> next cycle sram_rst = 1, then empty = 1, pointers 0, subsequent pop returns first post-flush push.
  - rst dropped mid-burst -> outputs take reset values immediately, without waiting for a clock edge.
